// File: rtl/master_rd_bridge_if.sv
`default_nettype none
// Bus bundle for master_rd_bridge: driver read port, memory request/response
// channels and status outputs. The bridge uses the slave view.
interface master_rd_bridge_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic [ADDR_W-1:0] drv_addr;
  logic              drv_rd;
  logic              drv_busy;
  logic [DATA_W-1:0] drv_data;
  logic              drv_data_val;
  logic              mem_req_val;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_rdy;
  logic              mem_rsp_val;
  logic [DATA_W-1:0] mem_rsp_data;
  logic [3:0]        outstanding;
  logic              err_overflow;
  logic              err_unexp;

  modport slave (
    input  drv_addr, drv_rd, mem_req_rdy, mem_rsp_val, mem_rsp_data,
    output drv_busy, drv_data, drv_data_val, mem_req_val, mem_req_addr,
           outstanding, err_overflow, err_unexp
  );

  modport master (
    output drv_addr, drv_rd, mem_req_rdy, mem_rsp_val, mem_rsp_data,
    input  drv_busy, drv_data, drv_data_val, mem_req_val, mem_req_addr,
           outstanding, err_overflow, err_unexp
  );
endinterface
`default_nettype wire

// File: rtl/master_rd_bridge.sv
`default_nettype none
// Read-request bridge: queues single-cycle driver read strobes, issues them to
// memory with valid/ready, bounds outstanding reads and returns data in order.
module master_rd_bridge #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 4
) (
  input  wire logic           clk,
  input  wire logic           reset,
  master_rd_bridge_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] fifo_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [3:0]        out_q, out_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              data_val_q, data_val_d;
  logic              err_ovf_q, err_ovf_d;
  logic              err_unexp_q, err_unexp_d;

  logic full, push, pop, req_val, rsp_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign push    = bus.drv_rd && !full;
  assign req_val = (count_q != '0) && (out_q < 4'(MAX_OUT));
  assign pop     = req_val && bus.mem_req_rdy;
  // A response with nothing in flight is a protocol error and is not forwarded.
  assign rsp_ok  = bus.mem_rsp_val && (out_q != 4'd0);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_d       = out_q;
    data_d      = data_q;
    data_val_d  = 1'b0;
    err_ovf_d   = err_ovf_q;
    err_unexp_d = err_unexp_q;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);

    if (pop && !rsp_ok)      out_d = out_q + 4'd1;
    else if (!pop && rsp_ok) out_d = out_q - 4'd1;

    if (rsp_ok) begin
      data_d     = bus.mem_rsp_data;
      data_val_d = 1'b1;
    end

    if (bus.drv_rd && full)                     err_ovf_d   = 1'b1;
    if (bus.mem_rsp_val && (out_q == 4'd0))     err_unexp_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_q       <= 4'd0;
      data_q      <= '0;
      data_val_q  <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_unexp_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_q       <= out_d;
      data_q      <= data_d;
      data_val_q  <= data_val_d;
      err_ovf_q   <= err_ovf_d;
      err_unexp_q <= err_unexp_d;
    end
  end

  // Storage needs no reset: the address output is gated by the entry count.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= bus.drv_addr;
  end

  assign bus.drv_busy     = full;
  assign bus.drv_data     = data_q;
  assign bus.drv_data_val = data_val_q;
  assign bus.mem_req_val  = req_val;
  assign bus.mem_req_addr = (count_q != '0) ? fifo_q[rd_ptr_q] : '0;
  assign bus.outstanding  = out_q;
  assign bus.err_overflow = err_ovf_q;
  assign bus.err_unexp    = err_unexp_q;
endmodule
`default_nettype wire

// File: tb/tb_master_rd_bridge.sv
`default_nettype none
// Directed self-checking bench for master_rd_bridge (DEPTH=4, MAX_OUT=4).
module tb_master_rd_bridge;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  master_rd_bridge_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  master_rd_bridge #(
    .ADDR_W(64), .DATA_W(64), .DEPTH(4), .MAX_OUT(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    bus.drv_addr     = '0;
    bus.drv_rd       = 1'b0;
    bus.mem_req_rdy  = 1'b0;
    bus.mem_rsp_val  = 1'b0;
    bus.mem_rsp_data = '0;

    // Reset state
    #3;
    check("rst_busy", 64'(bus.drv_busy), 64'd0);
    check("rst_data", bus.drv_data, 64'd0);
    check("rst_dval", 64'(bus.drv_data_val), 64'd0);
    check("rst_reqval", 64'(bus.mem_req_val), 64'd0);
    check("rst_reqaddr", bus.mem_req_addr, 64'd0);
    check("rst_out", 64'(bus.outstanding), 64'd0);
    check("rst_errs", {62'd0, bus.err_overflow, bus.err_unexp}, 64'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Single read
    bus.drv_rd = 1'b1; bus.drv_addr = 64'h1; bus.mem_req_rdy = 1'b1;
    tick();
    bus.drv_rd = 1'b0;
    check("single_reqval", 64'(bus.mem_req_val), 64'd1);
    check("single_reqaddr", bus.mem_req_addr, 64'h1);
    tick();
    check("single_out1", 64'(bus.outstanding), 64'd1);
    check("single_reqval_lo", 64'(bus.mem_req_val), 64'd0);
    tick();
    bus.mem_rsp_val = 1'b1; bus.mem_rsp_data = 64'h1234_5678_9ABC_DEC0;
    tick();
    bus.mem_rsp_val = 1'b0;
    check("single_dval", 64'(bus.drv_data_val), 64'd1);
    check("single_data", bus.drv_data, 64'h1234_5678_9ABC_DEC0);
    check("single_out0", 64'(bus.outstanding), 64'd0);
    tick();
    check("single_dval_lo", 64'(bus.drv_data_val), 64'd0);
    check("single_data_hold", bus.drv_data, 64'h1234_5678_9ABC_DEC0);

    // Burst of 6 with memory silent: 4 issue, 2 stay queued
    for (int i = 0; i < 6; i++) begin
      bus.drv_rd = 1'b1; bus.drv_addr = 64'h10 + 64'(i);
      tick();
    end
    bus.drv_rd = 1'b0;
    check("burst_out4", 64'(bus.outstanding), 64'd4);
    check("burst_reqval_lo", 64'(bus.mem_req_val), 64'd0);
    check("burst_head", bus.mem_req_addr, 64'h14);
    check("burst_busy", 64'(bus.drv_busy), 64'd0);
    tick();
    check("burst_out4_hold", 64'(bus.outstanding), 64'd4);
    // Six responses: out 3,3,3,2,1,0 as the two queued entries issue alongside
    for (int i = 0; i < 6; i++) begin
      bus.mem_rsp_val = 1'b1; bus.mem_rsp_data = 64'hD000 + 64'(i);
      tick();
      check("burst_dval", 64'(bus.drv_data_val), 64'd1);
      check("burst_data", bus.drv_data, 64'hD000 + 64'(i));
      case (i)
        0: begin
          check("burst_out_r0", 64'(bus.outstanding), 64'd3);
          check("burst_addr_r0", bus.mem_req_addr, 64'h14);
        end
        1: begin
          check("burst_out_r1", 64'(bus.outstanding), 64'd3);
          check("burst_addr_r1", bus.mem_req_addr, 64'h15);
        end
        2: check("burst_out_r2", 64'(bus.outstanding), 64'd3);
        3: check("burst_out_r3", 64'(bus.outstanding), 64'd2);
        4: check("burst_out_r4", 64'(bus.outstanding), 64'd1);
        default: check("burst_out_r5", 64'(bus.outstanding), 64'd0);
      endcase
    end
    bus.mem_rsp_val = 1'b0;
    tick();
    check("burst_empty_val", 64'(bus.mem_req_val), 64'd0);
    check("burst_empty_addr", bus.mem_req_addr, 64'd0);

    // Overflow: memory not ready, 5 strobes
    bus.mem_req_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.drv_rd = 1'b1; bus.drv_addr = 64'h20 + 64'(i);
      tick();
      if (i == 2) check("ovf_busy_3", 64'(bus.drv_busy), 64'd0);
      if (i == 3) begin
        check("ovf_busy_4", 64'(bus.drv_busy), 64'd1);
        check("ovf_err_before", 64'(bus.err_overflow), 64'd0);
      end
    end
    bus.drv_rd = 1'b0;
    check("ovf_err", 64'(bus.err_overflow), 64'd1);
    check("ovf_busy_5", 64'(bus.drv_busy), 64'd1);
    check("ovf_head", bus.mem_req_addr, 64'h20);
    bus.mem_req_rdy = 1'b1;
    tick();
    check("ovf_busy_clr", 64'(bus.drv_busy), 64'd0);
    check("ovf_out1", 64'(bus.outstanding), 64'd1);
    tick();
    tick();
    check("ovf_last_addr", bus.mem_req_addr, 64'h23);
    tick();
    check("ovf_drained", 64'(bus.mem_req_val), 64'd0);
    check("ovf_out4", 64'(bus.outstanding), 64'd4);
    check("ovf_err_sticky", 64'(bus.err_overflow), 64'd1);
    bus.mem_req_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.mem_rsp_val = 1'b1; bus.mem_rsp_data = 64'hE0 + 64'(i);
      tick();
    end
    bus.mem_rsp_val = 1'b0;
    check("ovf_out0", 64'(bus.outstanding), 64'd0);
    check("ovf_last_data", bus.drv_data, 64'hE3);

    // Stall: one request held while memory not ready
    bus.drv_rd = 1'b1; bus.drv_addr = 64'h40;
    tick();
    bus.drv_rd = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_val", 64'(bus.mem_req_val), 64'd1);
      check("stall_addr", bus.mem_req_addr, 64'h40);
      tick();
    end
    check("stall_out0", 64'(bus.outstanding), 64'd0);
    bus.mem_req_rdy = 1'b1;
    tick();
    check("stall_accept", 64'(bus.outstanding), 64'd1);
    check("stall_val_lo", 64'(bus.mem_req_val), 64'd0);
    bus.mem_rsp_val = 1'b1; bus.mem_rsp_data = 64'h4040;
    tick();
    bus.mem_rsp_val = 1'b0;
    check("stall_data", bus.drv_data, 64'h4040);
    check("stall_out_back", 64'(bus.outstanding), 64'd0);

    // Simultaneous issue and response with two outstanding
    for (int i = 0; i < 3; i++) begin
      bus.drv_rd = 1'b1; bus.drv_addr = 64'h50 + 64'(i);
      tick();
    end
    bus.drv_rd = 1'b0;
    check("sim_out2", 64'(bus.outstanding), 64'd2);
    check("sim_head", bus.mem_req_addr, 64'h52);
    bus.mem_rsp_val = 1'b1; bus.mem_rsp_data = 64'h5A;
    tick();
    check("sim_out_same", 64'(bus.outstanding), 64'd2);
    check("sim_dval", 64'(bus.drv_data_val), 64'd1);
    check("sim_empty", 64'(bus.mem_req_val), 64'd0);
    tick();
    tick();
    bus.mem_rsp_val = 1'b0;
    check("sim_out0", 64'(bus.outstanding), 64'd0);
    check("sim_unexp_clean", 64'(bus.err_unexp), 64'd0);

    // Reset mid-burst: 3 queued, 2 outstanding
    for (int i = 0; i < 3; i++) begin
      bus.drv_rd = 1'b1; bus.drv_addr = 64'h60 + 64'(i);
      tick();
    end
    bus.mem_req_rdy = 1'b0;
    for (int i = 3; i < 5; i++) begin
      bus.drv_addr = 64'h60 + 64'(i);
      tick();
    end
    bus.drv_rd = 1'b0;
    check("mid_out2", 64'(bus.outstanding), 64'd2);
    check("mid_head", bus.mem_req_addr, 64'h62);
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_out", 64'(bus.outstanding), 64'd0);
    check("mid_rst_val", 64'(bus.mem_req_val), 64'd0);
    check("mid_rst_addr", bus.mem_req_addr, 64'd0);
    check("mid_rst_data", bus.drv_data, 64'd0);
    check("mid_rst_busy", 64'(bus.drv_busy), 64'd0);
    check("mid_rst_errs", {62'd0, bus.err_overflow, bus.err_unexp}, 64'd0);
    tick();
    reset = 1'b1;
    bus.mem_rsp_val = 1'b1; bus.mem_rsp_data = 64'hBAD;
    tick();
    bus.mem_rsp_val = 1'b0;
    check("late_unexp", 64'(bus.err_unexp), 64'd1);
    check("late_dval", 64'(bus.drv_data_val), 64'd0);
    check("late_out", 64'(bus.outstanding), 64'd0);
    check("late_data", bus.drv_data, 64'd0);
    tick();
    check("late_unexp_sticky", 64'(bus.err_unexp), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
